// File: rtl/mod_counter_ctrl.sv
// mod_counter_ctrl: command sequencer around a programmable modulo-N counter.
// It accepts STOP/RUN/STEP/BURST over valid/ready and drives the counter,
// the terminal-count flag, a divide-by-wrap toggle and the burst done pulse.
module mod_counter_ctrl #(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned DEFAULT_MOD = 6,
  parameter int unsigned BURST_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [BURST_W-1:0] cmd_arg,
  input  logic               mod_wr,
  input  logic [WIDTH-1:0]   mod_val,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               tog,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BURST = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_STOP  = 2'd0,
    OP_RUN   = 2'd1,
    OP_STEP  = 2'd2,
    OP_BURST = 2'd3
  } op_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   mod_q, mod_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               tog_q, tog_d;
  logic               done_q, done_d;

  op_e  op;
  logic accept;
  logic advance;
  logic wrap;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state_q != S_STEP);
  assign accept    = cmd_valid && cmd_ready;
  assign tc        = (count_q == (mod_q - WIDTH'(1)));
  assign advance   = (state_q != S_IDLE);
  assign wrap      = advance && tc;

  assign count = count_q;
  assign tog   = tog_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign state = state_q;

  // State, counter, modulus, burst budget, toggle and done registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      mod_q   <= WIDTH'(DEFAULT_MOD);
      burst_q <= '0;
      tog_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mod_q   <= mod_d;
      burst_q <= burst_d;
      tog_q   <= tog_d;
      done_q  <= done_d;
    end
  end

  // Next-state: the advance is decided by the pre-edge state, commands
  // then select where the sequencer goes.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mod_d   = mod_q;
    burst_d = burst_q;
    tog_d   = tog_q;
    done_d  = 1'b0;

    if (advance) begin
      count_d = tc ? '0 : count_q + WIDTH'(1);
    end
    if (wrap) begin
      tog_d = ~tog_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (mod_wr && (mod_val >= WIDTH'(2))) begin
          mod_d   = mod_val;
          count_d = '0;
        end
        if (accept) begin
          unique case (op)
            OP_RUN:  state_d = S_RUN;
            OP_STEP: state_d = S_STEP;
            OP_BURST: begin
              if (cmd_arg != '0) begin
                state_d = S_BURST;
                burst_d = cmd_arg;
              end else begin
                done_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (accept && (op == OP_STOP)) begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        state_d = S_IDLE;
      end
      S_BURST: begin
        // STOP wins over a coinciding final wrap, so no done in that case.
        if (accept && (op == OP_STOP)) begin
          state_d = S_IDLE;
          burst_d = '0;
        end else if (wrap) begin
          if (burst_q > BURST_W'(1)) begin
            burst_d = burst_q - BURST_W'(1);
          end else begin
            state_d = S_IDLE;
            burst_d = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Bench for mod_counter_ctrl: directed test-plan sequences with literal
// expectations, then randomized commands, all compared every cycle against
// an integer-level behavioural model of the sequencer.
module tb_mod_counter_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic       mod_wr;
  logic [2:0] mod_val;
  logic [2:0] count;
  logic       tc;
  logic       tog;
  logic       busy;
  logic       done;
  logic [1:0] state;

  mod_counter_ctrl #(
    .WIDTH(3),
    .DEFAULT_MOD(6),
    .BURST_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_arg(cmd_arg),
    .mod_wr(mod_wr),
    .mod_val(mod_val),
    .count(count),
    .tc(tc),
    .tog(tog),
    .busy(busy),
    .done(done),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: 0 idle, 1 run, 2 step, 3 burst
  int m_state;
  int m_cnt;
  int m_mod;
  int m_tog;
  int m_done;
  int m_left;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_mod = 6; m_tog = 0; m_done = 0; m_left = 0;
  endtask

  // One clock edge of the sequencer as described by its command rules.
  task automatic model_step();
    bit moving, wrapped, acc;
    int ns, nc;
    moving  = (m_state != 0);
    wrapped = moving && (m_cnt == m_mod - 1);
    acc     = cmd_valid && (m_state != 2);
    ns = m_state;
    nc = moving ? (wrapped ? 0 : m_cnt + 1) : m_cnt;
    m_done = 0;
    if (wrapped) m_tog = 1 - m_tog;
    case (m_state)
      0: begin
        if (mod_wr && int'(mod_val) >= 2) begin
          m_mod = int'(mod_val);
          nc = 0;
        end
        if (acc) begin
          if (cmd_op == 2'd1) ns = 1;
          else if (cmd_op == 2'd2) ns = 2;
          else if (cmd_op == 2'd3) begin
            if (cmd_arg > 0) begin ns = 3; m_left = int'(cmd_arg); end
            else m_done = 1;
          end
        end
      end
      1: if (acc && cmd_op == 2'd0) ns = 0;
      2: ns = 0;
      default: begin
        if (acc && cmd_op == 2'd0) begin
          ns = 0; m_left = 0;
        end else if (wrapped) begin
          if (m_left > 1) m_left--;
          else begin ns = 0; m_left = 0; m_done = 1; end
        end
      end
    endcase
    m_state = ns;
    m_cnt   = nc;
  endtask

  task automatic check_all();
    chk("count", int'(count), m_cnt);
    chk("tc", int'(tc), (m_cnt == m_mod - 1) ? 1 : 0);
    chk("tog", int'(tog), m_tog);
    chk("done", int'(done), m_done);
    chk("state", int'(state), m_state);
    chk("busy", int'(busy), (m_state != 0) ? 1 : 0);
    chk("cmd_ready", int'(cmd_ready), (m_state != 2) ? 1 : 0);
  endtask

  // Called at a negedge: apply inputs, advance model, cross the edge, compare.
  task automatic tick(input bit v, input int op, input int arg, input bit wr, input int val);
    cmd_valid = v;
    cmd_op    = 2'(op);
    cmd_arg   = 4'(arg);
    mod_wr    = wr;
    mod_val   = 3'(val);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    tick(1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_b[6];
    exp_b = '{1, 2, 0, 1, 2, 0};
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0; mod_wr = 1'b0; mod_val = '0;
    model_reset();
    #1;
    check_all();
    chk("rst_state", int'(state), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // RUN at modulus 6 for 12 edges
    tick(1'b1, 1, 0, 1'b0, 0);
    chk("run_state", int'(state), 1);
    for (int k = 1; k <= 12; k++) begin
      idle();
      if (k == 5) begin chk("run_c5", int'(count), 5); chk("run_tc5", int'(tc), 1); end
      if (k == 6) begin chk("run_c6", int'(count), 0); chk("run_tog6", int'(tog), 1); end
      if (k == 12) begin chk("run_c12", int'(count), 0); chk("run_tog12", int'(tog), 0); end
    end
    tick(1'b1, 0, 0, 1'b0, 0);
    chk("stop_state", int'(state), 0);
    chk("stop_count", int'(count), 1);

    // Single steps from 0
    tick(1'b0, 0, 0, 1'b1, 6);
    chk("wr_clear", int'(count), 0);
    for (int s = 1; s <= 3; s++) begin
      tick(1'b1, 2, 0, 1'b0, 0);
      chk("step_ready0", int'(cmd_ready), 0);
      chk("step_state", int'(state), 2);
      idle();
      chk("step_count", int'(count), s);
      chk("step_idle", int'(state), 0);
      chk("step_ready1", int'(cmd_ready), 1);
    end

    // Burst of 2 wraps at modulus 3
    tick(1'b0, 0, 0, 1'b1, 3);
    chk("mod3_count", int'(count), 0);
    tick(1'b1, 3, 2, 1'b0, 0);
    chk("burst_state", int'(state), 3);
    for (int k = 0; k < 6; k++) begin
      idle();
      chk("burst_count", int'(count), exp_b[k]);
    end
    chk("burst_done", int'(done), 1);
    chk("burst_idle", int'(state), 0);
    idle();
    chk("burst_done_off", int'(done), 0);
    chk("burst_hold", int'(count), 0);

    // Burst interrupted by STOP
    tick(1'b0, 0, 0, 1'b1, 6);
    tick(1'b1, 3, 5, 1'b0, 0);
    repeat (4) idle();
    chk("bstop_pre", int'(count), 4);
    tick(1'b1, 0, 0, 1'b0, 0);
    chk("bstop_count", int'(count), 5);
    chk("bstop_state", int'(state), 0);
    chk("bstop_done", int'(done), 0);
    idle();
    chk("bstop_hold", int'(count), 5);
    chk("bstop_done2", int'(done), 0);

    // Ignored modulus writes and zero-length burst
    tick(1'b1, 1, 0, 1'b0, 0);
    tick(1'b0, 0, 0, 1'b1, 4);
    repeat (8) idle();
    tick(1'b1, 0, 0, 1'b0, 0);
    tick(1'b0, 0, 0, 1'b1, 1);
    tick(1'b1, 3, 0, 1'b0, 0);
    chk("b0_done", int'(done), 1);
    chk("b0_state", int'(state), 0);
    idle();
    chk("b0_done_off", int'(done), 0);

    // Asynchronous reset in the middle of a burst
    tick(1'b0, 0, 0, 1'b1, 6);
    tick(1'b1, 3, 5, 1'b0, 0);
    repeat (9) idle();
    chk("pre_rst_count", int'(count), 3);
    async_reset();
    chk("arst_count", int'(count), 0);
    chk("arst_tog", int'(tog), 0);
    chk("arst_state", int'(state), 0);
    chk("arst_done", int'(done), 0);
    tick(1'b1, 1, 0, 1'b0, 0);
    repeat (5) idle();
    chk("arst_mod6_tc", int'(tc), 1);
    tick(1'b1, 0, 0, 1'b0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit v, wr;
      int op, arg, val;
      if ($urandom_range(0, 399) == 0) async_reset();
      v   = ($urandom_range(0, 3) == 0);
      op  = int'($urandom_range(0, 3));
      arg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      wr  = ($urandom_range(0, 7) == 0);
      val = int'($urandom_range(0, 7));
      tick(v, op, arg, wr, val);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mod_counter_ctrl.md
Name: mod_counter_ctrl

Overview:
Sequencer for a programmable modulo-N counter datapath; it contains the counter register, wrap detection and divided toggle output. It accepts STOP/RUN/STEP/BURST commands over a valid/ready handshake and holds a modulus register that is writable only while idle. It sits between the board button/switch front end and the LED counter displays, replacing free-running counting with commanded operation.

Parameters:
WIDTH, 3, counter and modulus width in bits
DEFAULT_MOD, 6, modulus after reset; legal range 2..2^WIDTH-1
BURST_W, 4, width of the burst wrap-count argument

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted on an edge where cmd_valid&cmd_ready
cmd_op  input  2  00 STOP, 01 RUN, 10 STEP, 11 BURST
cmd_arg  input  BURST_W  number of wraps for BURST; ignored for other ops
mod_wr  input  1  load modulus strobe
mod_val  input  WIDTH  new modulus
count  output  WIDTH  registered counter value, 0..mod-1
tc  output  1  combinational, count==mod_reg-1
tog  output  1  toggles on every wrap
busy  output  1  state!=IDLE
done  output  1  one-cycle pulse at natural BURST completion
state  output  2  IDLE=0, RUN=1, STEP=2, BURST=3

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, mod_reg=DEFAULT_MOD, tog=0, done=0, burst_left=0. Reset mid-RUN or mid-BURST aborts immediately; no done.
- Advance: on any edge where registered state is RUN, STEP or BURST, count<=(tc ? 0 : count+1). A wrap is an advance with tc=1; on a wrap tog<=~tog. No advance in IDLE.
- cmd_ready=0 in STEP, 1 in all other states. Accepted commands take effect at the same edge; that edge's advance is governed by the pre-edge state.
- IDLE: RUN->RUN. STEP->STEP. BURST with cmd_arg>0 -> BURST, burst_left<=cmd_arg. BURST with cmd_arg=0 -> stay IDLE, done pulses next cycle. STOP -> no-op.
- RUN: STOP->IDLE. The acceptance edge still advances. RUN/STEP/BURST are accepted and dropped.
- STEP: exactly one advance, then IDLE unconditionally.
- BURST: a wrap with burst_left>1 decrements burst_left. A wrap with burst_left==1 -> IDLE, burst_left<=0, done=1 for the following cycle. STOP -> IDLE, no done; the acceptance edge still advances and a wrap on that edge toggles tog. Other ops are accepted and dropped. If STOP and the final wrap coincide, go to IDLE with no done.
- Modulus: mod_wr is honoured only in IDLE and with mod_val>=2. It sets mod_reg<=mod_val and count<=0. mod_val 0/1, or mod_wr outside IDLE, is ignored with no state change.
- If mod_wr and a command are accepted on the same IDLE edge, the modulus load applies and count=0. The new state then runs with the new modulus from the next edge.
- done is registered and never high for more than one cycle. tog is unaffected by a modulus write.

Test Plan:
- Reset then RUN, 12 edges, mod=6 -> count 0,1,..,5,0,..,5,0; tc high at count=5; tog toggles twice (0->1->0); busy=1.
- IDLE, STEP issued 3 times -> count 1,2,3. cmd_ready=0 for exactly one cycle after each STEP. state returns to 0.
- mod_wr mod_val=3, then BURST arg=2 -> count 0,1,2,0,1,2,0. done pulses once on the cycle after the second wrap; state=IDLE; count holds 0.
- BURST arg=5, STOP issued at count=4 during the first pass -> count reaches 5 on the STOP edge then holds; done stays 0; state=IDLE.
- mod_wr in RUN with mod_val=4 -> ignored, counting continues at mod 6. mod_wr in IDLE with mod_val=1 -> ignored, mod stays 6. BURST arg=0 -> done one cycle, no advance.
- Deassert rst mid-BURST at count=3 with tog=1 -> count=0, tog=0, state=IDLE, done=0 asynchronously; mod_reg returns to 6.
